// File: rtl/bcd_conv_seq_if.sv
// Request/result bundle between the CPU-side requester and the iterative BCD converter.
// The requester drives master; the converter owns slave.
interface bcd_conv_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  start;
    logic                  signed_mode;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  negative;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output signed_mode,
        output bin,
        input  busy,
        input  done,
        input  negative,
        input  bcd
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  bin,
        output busy,
        output done,
        output negative,
        output bcd
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Iterative binary-to-BCD converter (double-dabble), one operand bit per clock.
// Results are published only from FINISH, so bcd/negative never show partial values.
module bcd_conv_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_conv_seq_if.slave  io_bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW = 4 * DIGITS;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CW-1:0]   r_count;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]   r_bcd_w;
    logic            r_neg_w;
    logic [BW-1:0]   r_bcd;
    logic            r_neg;
    logic            r_done;

    logic             w_cap_neg;
    logic [WIDTH-1:0] w_cap_mag;
    logic [BW-1:0]    w_adj;

    // Magnitude stays WIDTH bits unsigned, so the most negative operand maps cleanly.
    assign w_cap_neg = io_bus.signed_mode & io_bus.bin[WIDTH-1];
    assign w_cap_mag = w_cap_neg ? (~io_bus.bin + WIDTH'(1)) : io_bus.bin;

    always_comb begin
        w_adj = r_bcd_w;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd_w[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd_w[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (io_bus.start) w_state_next = StShift;
            StShift:  if (r_count == LastCount) w_state_next = StFinish;
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_mag   <= '0;
            r_bcd_w <= '0;
            r_neg_w <= 1'b0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == StFinish);
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_mag   <= w_cap_mag;
                        r_neg_w <= w_cap_neg;
                        r_bcd_w <= '0;
                        r_count <= '0;
                    end
                end
                StShift: begin
                    // Adjust first, then the mag MSB enters the ones digit.
                    r_bcd_w <= {w_adj[BW-2:0], r_mag[WIDTH-1]};
                    r_mag   <= {r_mag[WIDTH-2:0], 1'b0};
                    if (r_count != LastCount) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                StFinish: begin
                    r_bcd <= r_bcd_w;
                    r_neg <= r_neg_w;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.busy     = (r_state != StIdle);
    assign io_bus.done     = r_done;
    assign io_bus.negative = r_neg;
    assign io_bus.bcd      = r_bcd;
endmodule
